// File: rtl/zmat_reader.sv
`default_nettype none
// ============================================================================
//  Module   : zmat_reader
//  Purpose  : Drains the VECTOR_SIZE x VECTOR_SIZE result matrix Z out of the
//             Z BRAM (row-major, index order) onto a valid/ready stream with an
//             end-of-matrix marker. A 2-entry output FIFO plus one pending-read
//             flag sustains one beat per cycle and absorbs sink back-pressure.
//  Options  : ZMAT_READER_ROW_END_EN - adds out_row_end, high on the last beat
//             of every matrix row.
//  Revision : 1.0 - initial release
// ============================================================================
module zmat_reader #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 6,
    parameter int VECTOR_SIZE = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] z_addr,
    output logic                  z_rd_en,
    input  logic [DATA_WIDTH-1:0] z_dout,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
`ifdef ZMAT_READER_ROW_END_EN
    output logic                  out_row_end,
`endif
    output logic                  out_last
);

    // Counters carry one extra bit so that N*N itself is representable.
    localparam int                c_TOTAL_INT = VECTOR_SIZE * VECTOR_SIZE;
    localparam int                c_LAST_INT  = c_TOTAL_INT - 1;
    localparam logic [ADDR_WIDTH:0] c_TOTAL    = c_TOTAL_INT[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] c_LAST_IDX = c_LAST_INT[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] c_ONE      = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [ADDR_WIDTH:0]   r_rd_idx;
    logic                  r_pending;
    logic                  r_pend_last;
    logic [DATA_WIDTH-1:0] r_fifo_data [2];
    logic [1:0]            r_fifo_last;
    logic                  r_head;
    logic [1:0]            r_count;

    logic [1:0]            w_occ;
    logic                  w_issue;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_tail;

`ifdef ZMAT_READER_ROW_END_EN
    localparam int                  c_COL_MAX_INT = VECTOR_SIZE - 1;
    localparam logic [ADDR_WIDTH:0] c_COL_MAX     = c_COL_MAX_INT[ADDR_WIDTH:0];
    logic [ADDR_WIDTH:0]   r_col;
    logic                  r_pend_row;
    logic [1:0]            r_fifo_row;
    assign out_row_end = r_fifo_row[r_head];
`endif

    // Stream side: the FIFO head is the visible beat.
    assign out_valid = (r_count != 2'd0);
    assign out_data  = r_fifo_data[r_head];
    assign out_last  = r_fifo_last[r_head];

    // A pop frees a slot in the same cycle, so ready feeds straight into the
    // issue decision to keep one beat per cycle under sustained ready.
    assign w_pop   = out_valid && out_ready;
    assign w_push  = r_pending;
    assign w_tail  = r_head ^ r_count[0];
    assign w_occ   = r_count + {1'b0, r_pending};
    assign w_issue = (r_state == S_ACTIVE) && (r_rd_idx < c_TOTAL) &&
                     ((w_occ < 2'd2) || ((w_occ == 2'd2) && w_pop));

    assign z_rd_en = w_issue;
    assign z_addr  = w_issue ? r_rd_idx[ADDR_WIDTH-1:0] : '0;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and status outputs; final handshake ends the drain.
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                busy = 1'b1;
                if (w_pop && out_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Read counter, pending-read tracking and the 2-entry output FIFO.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rd_idx       <= '0;
            r_pending      <= 1'b0;
            r_pend_last    <= 1'b0;
            r_fifo_data[0] <= '0;
            r_fifo_data[1] <= '0;
            r_fifo_last    <= 2'b00;
            r_head         <= 1'b0;
            r_count        <= 2'd0;
`ifdef ZMAT_READER_ROW_END_EN
            r_col          <= '0;
            r_pend_row     <= 1'b0;
            r_fifo_row     <= 2'b00;
`endif
        end else begin
            if ((r_state == S_IDLE) && start) begin
                r_rd_idx <= '0;
`ifdef ZMAT_READER_ROW_END_EN
                r_col    <= '0;
`endif
            end else if (w_issue) begin
                r_rd_idx <= r_rd_idx + c_ONE;
`ifdef ZMAT_READER_ROW_END_EN
                r_col    <= (r_col == c_COL_MAX) ? '0 : r_col + c_ONE;
`endif
            end

            // Beat attributes travel with the read until its data lands.
            r_pending <= w_issue;
            if (w_issue) begin
                r_pend_last <= (r_rd_idx == c_LAST_IDX);
`ifdef ZMAT_READER_ROW_END_EN
                r_pend_row  <= (r_col == c_COL_MAX);
`endif
            end

            if (w_push) begin
                r_fifo_data[w_tail] <= z_dout;
                r_fifo_last[w_tail] <= r_pend_last;
`ifdef ZMAT_READER_ROW_END_EN
                r_fifo_row[w_tail]  <= r_pend_row;
`endif
            end

            if (w_pop) begin
                r_head <= ~r_head;
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire
